// File: rtl/fft_frame_sched.sv
// fft_frame_sched: frame scheduler between the decimated-sample FIFO and the
// AXI-Stream input of the FFT/IFFT core. It waits for enough buffered samples,
// streams FFT_LEN samples per frame with tvalid/tlast, and absorbs tready
// back-pressure in a 2-entry skid buffer. It then inserts an inter-frame gap
// and stops after MAX_FRAMES frames (0 = unlimited).
//
// Optional stall watchdog: define FFT_SCHED_TIMEOUT_EN to enable it.
// Without the macro, stall_err is tied low.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | post-reset, moves to S_WAIT next cycle
// S_WAIT  | wait for enable, FIFO fill threshold and frame budget
// S_READ  | issue FFT_LEN FIFO reads, throttled by skid-buffer room
// S_DRAIN | all reads issued, stream out remaining beats up to tlast
// S_GAP   | inter-frame idle, GAP_CYCLES down-counter
// S_DONE  | frame budget exhausted, terminal until reset

module fft_frame_sched #(
   parameter int DATA_W      = 48,
   parameter int FFT_LEN     = 512,
   parameter int CNT_W       = 13,
   parameter int FILL_THRESH = 1500,
   parameter int MAX_FRAMES  = 6,
   parameter int GAP_CYCLES  = 3,
   parameter int TIMEOUT     = 4096
) (
   input  logic              SYS_CLK,
   input  logic              SYS_RSTN,
   input  logic              enable,
   input  logic [CNT_W-1:0]  fifo_rd_count,
   input  logic              fifo_empty,
   output logic              fifo_rd_en,
   input  logic [DATA_W-1:0] fifo_dout,
   input  logic              fifo_valid,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   output logic              m_axis_tlast,
   input  logic              m_axis_tready,
   output logic [15:0]       frame_cnt,
   output logic              busy,
   output logic              done,
   output logic              stall_err
);

   localparam int IW = $clog2(FFT_LEN + 1);
   localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam logic [IW-1:0]    LEN_C    = IW'(FFT_LEN);
   localparam logic [IW-1:0]    LAST_C   = IW'(FFT_LEN - 1);
   localparam logic [GW-1:0]    GAP_C    = GW'(GAP_CYCLES);
   localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(FILL_THRESH);
   localparam logic [15:0]      MAXF_C   = 16'(MAX_FRAMES);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WAIT  = 3'd1,
      S_READ  = 3'd2,
      S_DRAIN = 3'd3,
      S_GAP   = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     issued_q, issued_d;
   logic [IW-1:0]     beat_q, beat_d;
   logic [GW-1:0]     gap_q, gap_d;
   logic [15:0]       frame_q, frame_d;
   logic              inflight_q;
   logic [1:0]        occ_q, occ_d;
   logic [DATA_W-1:0] head_q, head_d;
   logic [DATA_W-1:0] tail_q, tail_d;

   logic       pop;
   logic       start_ok;
   logic       limit_hit;
   logic [2:0] lvl;
   logic [2:0] room;

   // AXI-Stream side is driven straight from the skid-buffer head
   assign m_axis_tvalid = (occ_q != 2'd0);
   assign m_axis_tdata  = head_q;
   assign m_axis_tlast  = m_axis_tvalid && (beat_q == LAST_C);
   assign pop           = m_axis_tvalid && m_axis_tready;

   // Reads in flight count against buffer room; a same-cycle pop frees a slot
   assign lvl        = {1'b0, occ_q} + {2'b00, inflight_q};
   assign room       = 3'd2 + {2'b00, pop};
   assign fifo_rd_en = (state_q == S_READ) && !fifo_empty &&
                       (issued_q != LEN_C) && (lvl < room);

   assign start_ok  = enable && (fifo_rd_count >= THRESH_C) &&
                      ((MAX_FRAMES == 0) || (frame_q < MAXF_C));
   assign limit_hit = (MAX_FRAMES != 0) && (frame_q == MAXF_C);

   assign frame_cnt = frame_q;
   assign busy      = (state_q == S_READ) || (state_q == S_DRAIN);
   assign done      = (state_q == S_DONE);

   // Next-state logic and per-frame counters
   always_comb begin
      state_d  = state_q;
      issued_d = issued_q;
      beat_d   = beat_q;
      gap_d    = gap_q;
      frame_d  = frame_q;
      if (fifo_rd_en) begin
         issued_d = issued_q + 1'b1;
      end
      if (pop) begin
         beat_d = beat_q + 1'b1;
      end
      if (pop && m_axis_tlast && (frame_q != 16'hFFFF)) begin
         frame_d = frame_q + 16'd1;
      end
      case (state_q)
         S_IDLE: state_d = S_WAIT;
         S_WAIT: begin
            if (start_ok) begin
               state_d  = S_READ;
               issued_d = '0;
               beat_d   = '0;
            end
         end
         S_READ: begin
            if (fifo_rd_en && (issued_q == LAST_C)) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (pop && m_axis_tlast) begin
               state_d = S_GAP;
               gap_d   = GAP_C;
            end
         end
         S_GAP: begin
            if (gap_q == '0) begin
               state_d = limit_hit ? S_DONE : S_WAIT;
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end
         S_DONE:  state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   // Skid buffer: every returning FIFO word is captured; head stays put while stalled
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      occ_d  = occ_q;
      case ({fifo_valid, pop})
         2'b10: begin
            if (occ_q == 2'd0) begin
               head_d = fifo_dout;
            end else if (occ_q == 2'd1) begin
               tail_d = fifo_dout;
            end
            if (occ_q != 2'd2) begin
               occ_d = occ_q + 2'd1;
            end
         end
         2'b01: begin
            head_d = tail_q;
            occ_d  = occ_q - 2'd1;
         end
         2'b11: begin
            if (occ_q == 2'd1) begin
               head_d = fifo_dout;
            end else begin
               head_d = tail_q;
               tail_d = fifo_dout;
            end
         end
         default: ;
      endcase
   end

   // State, counters and buffer registers
   always_ff @(posedge SYS_CLK) begin
      if (!SYS_RSTN) begin
         state_q    <= S_IDLE;
         issued_q   <= '0;
         beat_q     <= '0;
         gap_q      <= '0;
         frame_q    <= '0;
         inflight_q <= 1'b0;
         occ_q      <= 2'd0;
         head_q     <= '0;
         tail_q     <= '0;
      end else begin
         state_q    <= state_d;
         issued_q   <= issued_d;
         beat_q     <= beat_d;
         gap_q      <= gap_d;
         frame_q    <= frame_d;
         inflight_q <= fifo_rd_en;
         occ_q      <= occ_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
      end
   end

`ifdef FFT_SCHED_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam logic [WW-1:0] TO_C = WW'(TIMEOUT);

   logic [WW-1:0] wd_q, wd_d;
   logic          stall_q, stall_d;

   // Watchdog down-counter: reloads on every accepted beat or when not streaming
   always_comb begin
      wd_d    = wd_q;
      stall_d = stall_q;
      if (!busy || pop) begin
         wd_d = TO_C;
      end else if (wd_q != '0) begin
         wd_d = wd_q - 1'b1;
         if (wd_q == WW'(1)) begin
            stall_d = 1'b1;
         end
      end
   end

   // Watchdog registers; stall flag is sticky until reset
   always_ff @(posedge SYS_CLK) begin
      if (!SYS_RSTN) begin
         wd_q    <= TO_C;
         stall_q <= 1'b0;
      end else begin
         wd_q    <= wd_d;
         stall_q <= stall_d;
      end
   end

   assign stall_err = stall_q;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT != 0);
   assign stall_err      = 1'b0;
`endif

endmodule

// File: tb/tb_fft_frame_sched.sv
// tb_fft_frame_sched: directed/randomised bench for fft_frame_sched.
// Reference: a FIFO model that hands out 0,1,2,... plus a stream-level
// scoreboard (consecutive values, tlast every FFT_LEN-th accepted beat,
// AXI hold rule, at most 2 words buffered).
module tb_fft_frame_sched;

   localparam int DATA_W      = 48;
   localparam int FFT_LEN     = 8;
   localparam int CNT_W       = 13;
   localparam int FILL_THRESH = 10;
   localparam int MAX_FRAMES  = 3;
   localparam int GAP_CYCLES  = 3;
   localparam int TIMEOUT     = 16;

`ifdef FFT_SCHED_TIMEOUT_EN
   localparam bit WD_ON = 1'b1;
`else
   localparam bit WD_ON = 1'b0;
`endif

   logic              SYS_CLK    = 1'b0;
   logic              SYS_RSTN   = 1'b0;
   logic              enable     = 1'b0;
   logic [CNT_W-1:0]  fifo_rd_count = 13'd20;
   logic              fifo_empty = 1'b0;
   logic              fifo_rd_en;
   logic [DATA_W-1:0] fifo_dout  = '0;
   logic              fifo_valid = 1'b0;
   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tlast;
   logic              tready     = 1'b0;
   logic [15:0]       frame_cnt;
   logic              busy;
   logic              done;
   logic              stall_err;

   fft_frame_sched #(
      .DATA_W(DATA_W), .FFT_LEN(FFT_LEN), .CNT_W(CNT_W), .FILL_THRESH(FILL_THRESH),
      .MAX_FRAMES(MAX_FRAMES), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)
   ) dut (
      .SYS_CLK(SYS_CLK), .SYS_RSTN(SYS_RSTN), .enable(enable),
      .fifo_rd_count(fifo_rd_count), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
      .fifo_dout(fifo_dout), .fifo_valid(fifo_valid),
      .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tlast(tlast),
      .m_axis_tready(tready), .frame_cnt(frame_cnt), .busy(busy), .done(done),
      .stall_err(stall_err)
   );

   always #5 SYS_CLK = ~SYS_CLK;

   // FIFO model: incrementing pattern, data and valid one cycle after the read
   logic [DATA_W-1:0] next_val = '0;
   always @(posedge SYS_CLK) begin
      if (fifo_rd_en && SYS_RSTN && !fifo_empty) begin
         fifo_dout  <= next_val;
         next_val   <= next_val + 1'b1;
         fifo_valid <= 1'b1;
      end else begin
         fifo_valid <= 1'b0;
      end
   end

   int n_cmp = 0;
   int n_err = 0;

   int                cyc = 0;
   logic [DATA_W-1:0] exp_next;
   int                exp_beat, accepted, delivered, frames_seen;
   int                tl_cyc, fp_cyc, rd_cyc, rd_total;
   bit                gap_pending, prev_stall, rd_seen, v_seen, cont_chk;
   logic [DATA_W-1:0] prev_data;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Stream scoreboard, sampled at the falling edge
   task automatic monitor();
      bit pop;
      if (!SYS_RSTN) begin
         exp_next    = next_val;
         exp_beat    = 0;
         accepted    = 0;
         delivered   = 0;
         frames_seen = 0;
         gap_pending = 0;
         prev_stall  = 0;
         rd_seen     = 0;
         v_seen      = 0;
         return;
      end
      pop = tvalid && tready;
      if (prev_stall) begin
         check("hold_valid", tvalid, 1);
         check("hold_data", tdata, prev_data);
      end
      if (fifo_empty) check("rd_during_empty", fifo_rd_en, 0);
      if (fifo_rd_en) begin
         rd_total++;
         if (!rd_seen) begin
            rd_seen = 1;
            rd_cyc  = cyc;
         end
         if (gap_pending) begin
            check("frame_gap_ge4", (cyc - tl_cyc) >= 4, 1);
            gap_pending = 0;
         end
      end
      if (tvalid && !v_seen) begin
         v_seen = 1;
         check("first_valid_lat", cyc - rd_cyc, 2);
      end
      check("tlast", tlast, tvalid && (exp_beat == FFT_LEN - 1));
      if (fifo_valid) delivered++;
      if (pop) begin
         check("tdata", tdata, exp_next);
         if (exp_beat == 0) fp_cyc = cyc;
         if (exp_beat == FFT_LEN - 1) begin
            frames_seen++;
            tl_cyc      = cyc;
            gap_pending = 1;
            if (cont_chk) check("burst_len", cyc - fp_cyc, FFT_LEN - 1);
         end
         exp_next = exp_next + 1'b1;
         exp_beat = (exp_beat + 1) % FFT_LEN;
         accepted++;
      end
      if (fifo_valid || pop) check("skid_occ_le2", (delivered - accepted) <= 2, 1);
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
   endtask

   task automatic tick();
      @(negedge SYS_CLK);
      monitor();
      @(posedge SYS_CLK);
      #1;
      cyc++;
   endtask

   // mode 0: hold tready, 1: 1,0,0,1 pattern, 2: random
   task automatic run_frames(input int n, input int mode, input int budget, input string tag);
      int k = 0;
      while (frames_seen < n && k < budget) begin
         if (mode == 1) tready = ((k % 4) == 0) || ((k % 4) == 3);
         else if (mode == 2) tready = 1'($urandom_range(0, 1));
         tick();
         k++;
      end
      check(tag, frames_seen, n);
   endtask

   task automatic run_acc(input int n, input int budget, input string tag);
      int k = 0;
      while (accepted < n && k < budget) begin
         tick();
         k++;
      end
      check(tag, accepted, n);
   endtask

   task automatic wait_done(input int budget, input string tag);
      int k = 0;
      while (!done && k < budget) begin
         tready = 1'b1;
         tick();
         k++;
      end
      check(tag, done, 1);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_rd_en"}, fifo_rd_en, 0);
      check({tag, "_tvalid"}, tvalid, 0);
      check({tag, "_tlast"}, tlast, 0);
      check({tag, "_tdata"}, tdata, 0);
      check({tag, "_frame_cnt"}, frame_cnt, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_stall"}, stall_err, 0);
   endtask

   task automatic apply_reset(input string tag);
      SYS_RSTN   = 1'b0;
      enable     = 1'b0;
      tready     = 1'b0;
      fifo_empty = 1'b0;
      repeat (3) tick();
      check_reset_vals(tag);
      SYS_RSTN = 1'b1;
   endtask

   initial begin
      int rd0;
      int k;
      logic [DATA_W-1:0] base;

      // Basic frame and frame limit, tready held high
      apply_reset("rst0");
      cont_chk = 1;
      enable   = 1'b1;
      tready   = 1'b1;
      run_frames(1, 0, 100, "basic_frame");
      check("basic_frame_cnt", frame_cnt, 1);
      check("basic_next_data", exp_next, FFT_LEN);
      wait_done(300, "limit_done");
      check("limit_frame_cnt", frame_cnt, MAX_FRAMES);
      check("limit_frames_seen", frames_seen, MAX_FRAMES);
      check("limit_data_total", exp_next, MAX_FRAMES * FFT_LEN);
      rd0 = rd_total;
      repeat (30) tick();
      check("limit_no_reads", rd_total - rd0, 0);
      check("limit_cnt_hold", frame_cnt, MAX_FRAMES);
      check("limit_done_sticky", done, 1);
      cont_chk = 0;

      // Back-pressure: fixed pattern, then random, then FIFO underrun
      apply_reset("rst1");
      enable = 1'b1;
      run_frames(1, 1, 200, "bp_pattern");
      run_frames(2, 2, 300, "bp_random");
      base = next_val;
      k = 0;
      while (next_val != base + 5 && k < 100) begin
         tready = 1'($urandom_range(0, 1));
         tick();
         k++;
      end
      check("underrun_arm", next_val, base + 5);
      fifo_empty = 1'b1;
      repeat (10) begin
         tready = 1'($urandom_range(0, 1));
         tick();
      end
      fifo_empty = 1'b0;
      run_frames(3, 2, 300, "underrun_frame");
      wait_done(100, "bp_done");
      check("bp_frame_cnt", frame_cnt, MAX_FRAMES);

      // Enable drop mid-frame, then reset mid-frame
      apply_reset("rst2");
      enable = 1'b1;
      tready = 1'b1;
      run_acc(3, 100, "dis_arm");
      enable = 1'b0;
      run_frames(1, 0, 100, "dis_frame");
      rd0 = rd_total;
      repeat (30) tick();
      check("dis_busy", busy, 0);
      check("dis_no_reads", rd_total - rd0, 0);
      check("dis_frame_cnt", frame_cnt, 1);
      check("dis_not_done", done, 0);
      enable = 1'b1;
      run_acc(FFT_LEN + 4, 100, "midrst_arm");
      SYS_RSTN = 1'b0;
      tick();
      check_reset_vals("midrst");
      repeat (2) tick();
      SYS_RSTN = 1'b1;

      // Watchdog: tready low for 20 cycles mid-frame
      enable = 1'b1;
      tready = 1'b1;
      run_acc(2, 100, "wd_arm");
      tready = 1'b0;
      repeat (15) tick();
      check("wd_stall_15", stall_err, 0);
      tick();
      check("wd_stall_16", stall_err, WD_ON);
      repeat (4) tick();
      tready = 1'b1;
      run_frames(1, 0, 100, "wd_frame");
      check("wd_stall_sticky", stall_err, WD_ON);
      check("wd_frame_cnt", frame_cnt, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
